// File: rtl/lc3b_mem_arbiter.sv
// lc3b_mem_arbiter: shares the single-ported unified LC-3b RAM between the
// fetch stage (instruction reads) and the memory stage (data reads/writes).
// One requester is granted at a time. The RAM is driven from captured copies
// of the grantee's request for MEM_LAT cycles, then a one-cycle ready pulse
// (if_r / mem_r) is returned.
//
// Build option: define LC3B_MEM_ARB_RR_EN to alternate grants on contention
// (round-robin). Without it, MEM always wins over IF on contention.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | no transaction; requests are sampled and one is granted
// ACCESS | RAM enabled from captured regs for MEM_LAT cycles
// DONE   | one-cycle ready pulse to the grantee; no new grant this cycle
module lc3b_mem_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int MEM_LAT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_r,
    input  logic              mem_req,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_we_lo,
    input  logic              mem_we_hi,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_r,
    output logic              ram_en,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we_lo,
    output logic              ram_we_hi,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy
);

    localparam int CNT_W = $clog2(MEM_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic              grant_mem;     // 1: current grantee is MEM, 0: IF
    logic [ADDR_W-1:0] cap_addr;
    logic              cap_we_lo;
    logic              cap_we_hi;
    logic [DATA_W-1:0] cap_wdata;
    logic              do_grant;
    logic              pick_mem;
    logic              do_latch;
    logic              prio_mem;      // who wins when both request

`ifdef LC3B_MEM_ARB_RR_EN
    logic last_grant_mem;

    // Remember the most recent grantee so contention alternates; reset = IF,
    // which makes the first contention after reset go to MEM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_mem <= 1'b0;
        end else if (do_grant) begin
            last_grant_mem <= pick_mem;
        end
    end

    assign prio_mem = ~last_grant_mem;
`else
    assign prio_mem = 1'b1;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state, arbitration decision and status/handshake outputs.
    always_comb begin
        state_nxt = state;
        do_grant  = 1'b0;
        pick_mem  = 1'b0;
        do_latch  = 1'b0;
        ram_en    = 1'b0;
        if_r      = 1'b0;
        mem_r     = 1'b0;
        busy      = 1'b1;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (if_req || mem_req) begin
                    do_grant  = 1'b1;
                    pick_mem  = mem_req && (!if_req || prio_mem);
                    state_nxt = S_ACCESS;
                end
            end
            S_ACCESS: begin
                ram_en = 1'b1;
                if (cnt == '0) begin
                    do_latch  = 1'b1;
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if_r      = ~grant_mem;
                mem_r     = grant_mem;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Capture the grantee's request, run the access timer, latch read data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            grant_mem <= 1'b0;
            cap_addr  <= '0;
            cap_we_lo <= 1'b0;
            cap_we_hi <= 1'b0;
            cap_wdata <= '0;
            if_rdata  <= '0;
            mem_rdata <= '0;
        end else begin
            if (do_grant) begin
                cnt       <= CNT_LOAD;
                grant_mem <= pick_mem;
                cap_addr  <= pick_mem ? mem_addr : if_addr;
                // Fetches are always reads regardless of the MEM write strobes.
                cap_we_lo <= pick_mem & mem_we_lo;
                cap_we_hi <= pick_mem & mem_we_hi;
                cap_wdata <= pick_mem ? mem_wdata : '0;
            end else if (state == S_ACCESS && cnt != '0) begin
                cnt <= cnt - CNT_ONE;
            end
            if (do_latch && !cap_we_lo && !cap_we_hi) begin
                if (grant_mem) begin
                    mem_rdata <= ram_rdata;
                end else begin
                    if_rdata <= ram_rdata;
                end
            end
        end
    end

    // RAM side is driven purely from the captured copy; strobes only in ACCESS.
    assign ram_addr  = cap_addr;
    assign ram_wdata = cap_wdata;
    assign ram_we_lo = ram_en & cap_we_lo;
    assign ram_we_hi = ram_en & cap_we_hi;

endmodule

// File: tb/tb_lc3b_mem_arbiter.sv
// Self-checking bench for lc3b_mem_arbiter (MEM_LAT=4). A behavioural RAM
// whose read data is valid only on the last access cycle sits on the RAM
// port; expectations come from a transaction-level model (expected memory
// image, last grantee, previous load value).
module tb_lc3b_mem_arbiter;

    localparam int ADDR_W   = 16;
    localparam int DATA_W   = 16;
    localparam int MEM_LAT  = 4;
    localparam int R_CYC    = MEM_LAT + 1;
    localparam int TX_CYC   = MEM_LAT + 2;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              if_req = 1'b0;
    logic [ADDR_W-1:0] if_addr = '0;
    logic [DATA_W-1:0] if_rdata;
    logic              if_r;
    logic              mem_req = 1'b0;
    logic [ADDR_W-1:0] mem_addr = '0;
    logic              mem_we_lo = 1'b0;
    logic              mem_we_hi = 1'b0;
    logic [DATA_W-1:0] mem_wdata = '0;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_r;
    logic              ram_en;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we_lo;
    logic              ram_we_hi;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic              busy;

    int checks   = 0;
    int failures = 0;

    lc3b_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_r(if_r),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_we_lo(mem_we_lo),
        .mem_we_hi(mem_we_hi), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_r(mem_r), .ram_en(ram_en), .ram_addr(ram_addr),
        .ram_we_lo(ram_we_lo), .ram_we_hi(ram_we_hi), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] init_val(input int i);
        return 16'(i * 7 + 3) ^ 16'hA5C3;
    endfunction

    // Behavioural RAM: read data only valid on the MEM_LAT-th enabled cycle.
    logic [15:0] ram [0:65535];
    int          acc_cnt;
    bit          ram_inited = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_cnt <= 0;
            if (!ram_inited) begin
                for (int i = 0; i < 65536; i++) ram[i] <= init_val(i);
                ram[16'h3000] <= 16'h1234;
                ram_inited <= 1'b1;
            end
        end else if (ram_en) begin
            acc_cnt <= acc_cnt + 1;
            if (ram_we_lo) ram[ram_addr][7:0]  <= ram_wdata[7:0];
            if (ram_we_hi) ram[ram_addr][15:8] <= ram_wdata[15:8];
        end else begin
            acc_cnt <= 0;
        end
    end

    assign ram_rdata = (ram_en && acc_cnt == MEM_LAT - 1) ? ram[ram_addr] : 16'hDEAD;

    logic [69:0] outs;
    assign outs = {if_rdata, if_r, mem_rdata, mem_r, ram_en, ram_addr,
                   ram_we_lo, ram_we_hi, ram_wdata, busy};

    // Reference model state.
    logic [15:0] exp_mem [0:65535];
    bit          m_last_mem;
    logic [15:0] m_mem_rdata;

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Contention winner under the configured policy.
    function automatic bit contention_to_mem();
`ifdef LC3B_MEM_ARB_RR_EN
        return !m_last_mem;
`else
        return 1'b1;
`endif
    endfunction

    task automatic model_reset();
        m_last_mem  = 1'b0;
        m_mem_rdata = 16'h0000;
    endtask

    task automatic model_mem(input logic [15:0] ma, input bit wlo, input bit whi,
                             input logic [15:0] wd, output logic [15:0] d);
        if (!wlo && !whi) m_mem_rdata = exp_mem[ma];
        d = m_mem_rdata;
        if (wlo) exp_mem[ma][7:0]  = wd[7:0];
        if (whi) exp_mem[ma][15:8] = wd[15:8];
        m_last_mem = 1'b1;
    endtask

    // One arbitration round from IDLE; caller is 1 time unit after a posedge.
    task automatic run_round(input bit do_if, input bit do_mem,
                             input logic [15:0] ia, input logic [15:0] ma,
                             input bit wlo, input bit whi, input logic [15:0] wd);
        int          exp_if_c, exp_mem_c, got_if_c, got_mem_c;
        logic [15:0] exp_if_d, exp_mem_d, got_if_d, got_mem_d;
        bit          mem_first;
        exp_if_c  = -1; exp_mem_c = -1; got_if_c = -1; got_mem_c = -1;
        exp_if_d  = '0; exp_mem_d = '0; got_if_d = '0; got_mem_d = '0;
        mem_first = do_mem && (!do_if || contention_to_mem());
        if (mem_first) begin
            model_mem(ma, wlo, whi, wd, exp_mem_d);
            exp_mem_c = R_CYC;
            if (do_if) begin
                exp_if_d = exp_mem[ia]; m_last_mem = 1'b0; exp_if_c = R_CYC + TX_CYC;
            end
        end else begin
            exp_if_d = exp_mem[ia]; m_last_mem = 1'b0; exp_if_c = R_CYC;
            if (do_mem) begin
                model_mem(ma, wlo, whi, wd, exp_mem_d);
                exp_mem_c = R_CYC + TX_CYC;
            end
        end

        if (do_if) begin if_req = 1'b1; if_addr = ia; end
        if (do_mem) begin
            mem_req = 1'b1; mem_addr = ma; mem_we_lo = wlo; mem_we_hi = whi; mem_wdata = wd;
        end
        @(posedge clk);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            chk("r_overlap", 80'(if_r & mem_r), 80'd0);
            if (if_r && got_if_c < 0)  begin got_if_c  = c; got_if_d  = if_rdata;  end
            if (mem_r && got_mem_c < 0) begin got_mem_c = c; got_mem_d = mem_rdata; end
            @(posedge clk);
            #1;
            if (got_if_c >= 0)  if_req  = 1'b0;
            if (got_mem_c >= 0) mem_req = 1'b0;
            if ((!do_if || got_if_c >= 0) && (!do_mem || got_mem_c >= 0)) break;
        end
        if_req = 1'b0; mem_req = 1'b0; mem_we_lo = 1'b0; mem_we_hi = 1'b0;
        if (do_if) begin
            chk("if_r_cycle", 80'(got_if_c), 80'(exp_if_c));
            chk("if_rdata",   80'(got_if_d), 80'(exp_if_d));
        end
        if (do_mem) begin
            chk("mem_r_cycle", 80'(got_mem_c), 80'(exp_mem_c));
            chk("mem_rdata",   80'(got_mem_d), 80'(exp_mem_d));
        end
    endtask

    initial begin
        logic [15:0] ia, ma, wd;
        logic [1:0]  ws;
        int          kind;
        int          got_who [4];
        int          got_cyc [4];
        int          n;
        bit          e;

        for (int i = 0; i < 65536; i++) exp_mem[i] = init_val(i);
        exp_mem[16'h3000] = 16'h1234;
        model_reset();

        // 1: reset with random inputs, then quiet release
        #1 rst = 1'b1;
        if_req = 1'($urandom); mem_req = 1'($urandom);
        if_addr = 16'($urandom); mem_addr = 16'($urandom);
        mem_we_lo = 1'($urandom); mem_we_hi = 1'($urandom); mem_wdata = 16'($urandom);
        #12;
        chk("reset_outs", 80'(outs), 80'd0);
        @(negedge clk);
        chk("reset_outs_clk", 80'(outs), 80'd0);
        if_req = 1'b0; mem_req = 1'b0; mem_we_lo = 1'b0; mem_we_hi = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("idle_outs", 80'(outs), 80'd0);
        @(posedge clk); #1;

        // 2: single fetch, address changed mid-access must be ignored
        if_addr = 16'h3000; if_req = 1'b1;
        @(posedge clk); #1 if_addr = 16'hBEEF;
        for (int k = 1; k <= MEM_LAT; k++) begin
            @(negedge clk);
            chk("t2_ram_en",   80'(ram_en),   80'd1);
            chk("t2_ram_addr", 80'(ram_addr), 80'h3000);
            chk("t2_if_r_low", 80'(if_r),     80'd0);
        end
        @(negedge clk);
        chk("t2_if_r",     80'(if_r),     80'd1);
        chk("t2_if_rdata", 80'(if_rdata), 80'h1234);
        chk("t2_ram_en_done", 80'(ram_en), 80'd0);
        @(posedge clk); #1 if_req = 1'b0; if_addr = 16'h3000;
        @(negedge clk);
        chk("t2_if_r_pulse", 80'(if_r),     80'd0);
        chk("t2_if_hold",    80'(if_rdata), 80'h1234);
        chk("t2_busy",       80'(busy),     80'd0);
        m_last_mem = 1'b0;
        @(posedge clk); #1;

        // 3: simultaneous IF and MEM read
        run_round(1'b1, 1'b1, 16'h3000, 16'h4000, 1'b0, 1'b0, 16'h0000);

        // 4: MEM high-byte write, strobes changed mid-access must be ignored
        mem_addr = 16'h4001; mem_we_hi = 1'b1; mem_we_lo = 1'b0;
        mem_wdata = 16'hAB00; mem_req = 1'b1;
        @(posedge clk); #1 mem_wdata = 16'hFFFF; mem_we_lo = 1'b1; mem_addr = 16'h0000;
        for (int k = 1; k <= MEM_LAT; k++) begin
            @(negedge clk);
            chk("t4_ram_we_hi", 80'(ram_we_hi), 80'd1);
            chk("t4_ram_we_lo", 80'(ram_we_lo), 80'd0);
            chk("t4_ram_wdata", 80'(ram_wdata), 80'hAB00);
            chk("t4_ram_addr",  80'(ram_addr),  80'h4001);
        end
        @(negedge clk);
        chk("t4_mem_r",     80'(mem_r),     80'd1);
        chk("t4_mem_rdata", 80'(mem_rdata), 80'(m_mem_rdata));
        chk("t4_we_done",   80'({ram_we_hi, ram_we_lo}), 80'd0);
        @(posedge clk); #1 mem_req = 1'b0; mem_we_lo = 1'b0; mem_we_hi = 1'b0;
        exp_mem[16'h4001][15:8] = 8'hAB;
        m_last_mem = 1'b1;
        @(posedge clk); #1;
        run_round(1'b0, 1'b1, 16'h0000, 16'h4001, 1'b0, 1'b0, 16'h0000);

        // 5: reset in cycle 2 of a fetch, held request re-granted afterwards
        if_addr = 16'h3000; if_req = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t5_ram_en", 80'(ram_en), 80'd0);
        chk("t5_if_r",   80'(if_r),   80'd0);
        chk("t5_busy",   80'(busy),   80'd0);
        model_reset();
        @(posedge clk); #1 rst = 1'b0;
        run_round(1'b1, 1'b0, 16'h3000, 16'h0000, 1'b0, 1'b0, 16'h0000);

        // 6: both requests held continuously for four transactions
        if_addr = 16'h3000; mem_addr = 16'h4000; mem_we_lo = 1'b0; mem_we_hi = 1'b0;
        if_req = 1'b1; mem_req = 1'b1;
        n = 0;
        for (int k = 0; k < 4; k++) begin got_who[k] = -1; got_cyc[k] = -1; end
        @(posedge clk);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if ((if_r || mem_r) && n < 4) begin
                got_who[n] = mem_r ? 1 : 0; got_cyc[n] = c; n++;
            end
            if (n == 4) break;
        end
        @(posedge clk); #1 if_req = 1'b0; mem_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            e = contention_to_mem();
            m_last_mem = e;
            if (e) m_mem_rdata = exp_mem[16'h4000];
            chk("t6_grantee", 80'(got_who[k]), 80'(e ? 1 : 0));
            chk("t6_cycle",   80'(got_cyc[k]), 80'(R_CYC + k * TX_CYC));
        end

        // randomized rounds over a small address pool
        for (int r = 0; r < 40; r++) begin
            kind = int'($urandom_range(0, 2));
            ia = 16'h5000 + 16'($urandom_range(0, 3));
            ma = 16'h5000 + 16'($urandom_range(0, 3));
            ws = 2'($urandom_range(0, 3));
            wd = 16'($urandom);
            run_round(kind != 1, kind != 0, ia, ma, ws[0], ws[1], wd);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
